shift_tx_ctrl: RTL
==================

// Module: shift_tx_ctrl
// PURPOSE
//  Sequencer for the right-to-left parallel-load shift register used as a serializer.
//  Accepts a parallel word over a Valid/Ready handshake and loads it into the shifter.
//  Then clocks the word out LSB first on SerOut, with an optional parity bit.
//  Sits between a word-producing client and a single-wire serial sink.
// PARAMETERS
//  N      4   word width in bits (N >= 2)
// PORTS
//  Clk       in   1   single clock, all state on posedge Clk
//  Rst       in   1   asynchronous, active-high reset
//  Data      in   N   parallel word, sampled on accept
//  Valid     in   1   client offers Data
//  Ready     out  1   controller can accept (IDLE only)
//  SerOut    out  1   serial bit; 1 when idle
//  SerValid  out  1   SerOut carries a data/parity bit this cycle
//  Busy      out  1   word in flight (state != IDLE)
//  Done      out  1   one-cycle pulse after last bit leaves
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, Ready=1, SerOut=1, SerValid=0, Busy=0, Done=0.
//   Shifter contents are not reset; they are masked until the next load.
//  States: IDLE -> SHIFT -> (PAR) -> IDLE.
//  IDLE: Ready=1. Accept = Valid & Ready.
//   On the accept edge: L=1 to the shifter (Q<=Data), cnt<=0, state<=SHIFT.
//  SHIFT: SerOut=Q[0], SerValid=1, L=0, shifter In=1, cnt increments each cycle.
//   Bit i of Data appears in cycle i+1 after the accept edge, for i=0..N-1.
//   When cnt==N-1: state<=PAR if parity is built, else state<=IDLE.
//  PAR (macro only): SerOut=par_q, SerValid=1, state<=IDLE.
//  Done: 1 in the first IDLE cycle after the last bit; Ready is also 1 in that cycle.
//   A word can therefore be accepted in the same cycle Done pulses.
//  Throughput: one word per N+1 cycles (N+2 with parity); Ready is low while Busy.
//  Valid while Busy: ignored. Data is not sampled, and no queueing occurs.
//  Data changing after accept: no effect; the word is already held in the shifter.
//  cnt width = $clog2(N); cnt never exceeds N-1 (no wrap-around).
//  Rst asserted mid-word: return to IDLE immediately.
//   SerOut=1, SerValid=0, no Done pulse; the partial word is discarded.
//  Simultaneous Rst and Valid: Rst wins, nothing is accepted.
// CONFIGURATION
//  SHIFT_TX_PARITY_EN defined:
//   par_q <= ^Data is captured on accept (even parity).
//   One PAR cycle follows bit N-1, so a word takes N+2 cycles.
//  SHIFT_TX_PARITY_EN undefined:
//   No PAR state and no par_q register; a word takes N+1 cycles.
// STRUCTURE
//  Package shift_tx_pkg:
//   state enum {IDLE, SHIFT, PAR}
//   function cnt_w(N) = $clog2(N)
//  Sub-module shift_reg_rl #(N): parallel-load, right-to-left shifter.
//   Ports (L, R, Clk, In, Q), no reset; serial output is Q[0].
//  Controller logic: FSM, counter, par_q, and the output mux for SerOut.
// TESTING
//  1 N=4, Data=4'b1011, Valid pulsed in IDLE
//    -> SerOut=1,1,0,1 on cycles 1-4 with SerValid=1.
//    -> Done=1 and Ready=1 on cycle 5.
//  2 Same word with SHIFT_TX_PARITY_EN
//    -> bits 1,1,0,1, then parity 1 on cycle 5, Done on cycle 6.
//  3 Valid held high with Data=4'h3 then 4'hC
//    -> accepts on cycle 0 and cycle 5 only; serial stream 1,1,0,0 then 0,0,1,1.
//  4 Valid pulsed while Busy (cycle 2)
//    -> ignored; Ready stays 0 and the stream is unchanged.
//  5 Rst asserted on cycle 2 of a word
//    -> async: SerOut=1, SerValid=0, Ready=1 before the next edge; no Done.
//    -> the next accepted word serializes correctly.
//  6 N=8, Data=8'hA5 -> SerOut=1,0,1,0,0,1,0,1; Done on cycle 9.

Source files
------------

// File: rtl/shift_tx_pkg.sv
// Shared types for the serializer controller: FSM state encoding and counter sizing.
// Used by shift_tx_ctrl; the PAR state is only reachable when SHIFT_TX_PARITY_EN is defined.
package shift_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;

   // Bit-counter width; clamped to 1 so a degenerate width can never be produced.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/shift_reg_rl.sv
// Parallel-load shifter moving bits toward Q[0]; L loads D, R shifts In into the MSB.
// No reset: contents are don't-care until the controller loads a word.
module shift_reg_rl #(
   parameter int N = 4
) (
   input  logic         Clk,
   input  logic         L,
   input  logic         R,
   input  logic         In,
   input  logic [N-1:0] D,
   output logic [N-1:0] Q
);

   always_ff @(posedge Clk) begin
      if (L) begin
         Q <= D;
      end else if (R) begin
         Q <= {In, Q[N-1:1]};
      end
   end

endmodule

// File: rtl/shift_tx_ctrl.sv
// Serializer sequencer: accepts a word on Valid/Ready, shifts it out LSB first on SerOut.
// Define SHIFT_TX_PARITY_EN to append one even-parity bit after the data bits.
module shift_tx_ctrl
   import shift_tx_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic [N-1:0] Data,
   input  logic         Valid,
   output logic         Ready,
   output logic         SerOut,
   output logic         SerValid,
   output logic         Busy,
   output logic         Done
);

   localparam int            CW       = cnt_w(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          done_q, done_nxt;
   logic          load, shift_en;
   logic [N-1:0]  q;
   logic          unused_q;

   // Handshake: a word is accepted on a rising edge where Valid & Ready; Ready is high only in IDLE.
   shift_reg_rl #(.N(N)) u_shift (
      .Clk (Clk),
      .L   (load),
      .R   (shift_en),
      .In  (1'b1),
      .D   (Data),
      .Q   (q)
   );

   assign unused_q = ^q[N-1:1];

`ifdef SHIFT_TX_PARITY_EN
   logic par_q;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         par_q <= 1'b0;
      end else if (load) begin
         par_q <= ^Data;
      end
   end
`endif

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state  <= IDLE;
         cnt    <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         done_q <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      load      = 1'b0;
      shift_en  = 1'b0;
      Ready     = 1'b0;
      SerOut    = 1'b1;
      SerValid  = 1'b0;
      case (state)
         IDLE: begin
            Ready = 1'b1;
            if (Valid) begin
               load      = 1'b1;
               cnt_nxt   = '0;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            SerOut   = q[0];
            SerValid = 1'b1;
            shift_en = 1'b1;
            if (cnt == CNT_LAST) begin
               cnt_nxt = '0;
`ifdef SHIFT_TX_PARITY_EN
               state_nxt = PAR;
`else
               state_nxt = IDLE;
               done_nxt  = 1'b1;
`endif
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         PAR: begin
`ifdef SHIFT_TX_PARITY_EN
            SerOut   = par_q;
            SerValid = 1'b1;
            done_nxt = 1'b1;
`endif
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign Busy = (state != IDLE);
   assign Done = done_q;

endmodule
